// File: rtl/div_pkg.sv
// div_pkg: FSM encoding and counter sizing shared by the restoring divider files.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/acc_div.sv
// acc_div: remainder/quotient shift-subtract register, one restoring step per Step pulse.
module acc_div
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Step,
    input  logic [WIDTH-1:0] Dividendo,
    input  logic [WIDTH-1:0] Divisor,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Quociente,
    output logic [WIDTH-1:0] Resto
);

    // the remainder's extra top bit is always 0 after a commit, so only WIDTH bits are stored
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   s;
    logic [WIDTH:0]   t;

    always_comb begin
        s = {r, q[WIDTH-1]};
        t = s - {1'b0, D};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r <= '0;
            q <= '0;
        end else if (Load) begin
            r <= (Divisor == '0) ? Dividendo : '0;
            q <= (Divisor == '0) ? '1 : Dividendo;
        end else if (Step) begin
            r <= t[WIDTH] ? s[WIDTH-1:0] : t[WIDTH-1:0];
            q <= {q[WIDTH-2:0], ~t[WIDTH]};
        end
    end

    assign Quociente = q;
    assign Resto     = r;

endmodule

// File: rtl/divisor_restaurador.sv
// divisor_restaurador: sequential unsigned restoring divider (DIV/DIVU unit).
// Control FSM and iteration counter here; the datapath lives in acc_div.
module divisor_restaurador
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividendo,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quociente,
    output logic [WIDTH-1:0] Resto,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] d;
    logic             zero;
    logic             load;
    logic             step;

    assign zero = (Divisor == '0);
    assign load = (state == IDLE) && Start;
    assign step = (state == CALC);

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= next;
    end

    // a zero divisor skips the iterations and reports through FIN directly
    always_comb begin
        next = (state == IDLE) ? (Start ? (zero ? FIN : CALC) : IDLE) :
               (state == CALC) ? ((cnt == CW'(1)) ? FIN : CALC) :
               IDLE;
    end

    always_comb begin
        Busy = (state == CALC);
        Done = (state == FIN);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt     <= '0;
            d       <= '0;
            DivZero <= 1'b0;
        end else if (load) begin
            cnt     <= zero ? '0 : CW'(WIDTH);
            d       <= Divisor;
            DivZero <= zero;
        end else if (step) begin
            cnt     <= cnt - CW'(1);
        end
    end

    acc_div #(.WIDTH(WIDTH)) u_acc (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (load),
        .Step      (step),
        .Dividendo (Dividendo),
        .Divisor   (Divisor),
        .D         (d),
        .Quociente (Quociente),
        .Resto     (Resto)
    );

endmodule

// File: tb/tb_divisor_restaurador.sv
// tb_divisor_restaurador: directed and random checks of the divider against a / and % model.
module tb_divisor_restaurador;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] Dividendo;
    logic [15:0] Divisor;
    logic [15:0] Quociente;
    logic [15:0] Resto;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    int vectors;
    int miscompares;

    divisor_restaurador #(.WIDTH(16)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Dividendo (Dividendo),
        .Divisor   (Divisor),
        .Quociente (Quociente),
        .Resto     (Resto),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? 16'hFFFF : a / b;
    endfunction

    function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? a : a % b;
    endfunction

    // one full operation: launch, scramble operands, wait for Done, check timing and results
    task automatic do_div(input logic [15:0] a, input logic [15:0] b, input string tag);
        int cyc;
        int busy_n;
        @(negedge Clk);
        Start = 1'b1; Dividendo = a; Divisor = b;
        @(negedge Clk);
        Start = 1'b0; Dividendo = 16'($urandom); Divisor = 16'($urandom);
        cyc = 1;
        busy_n = int'(Busy);
        while (!Done && cyc < 40) begin
            @(negedge Clk);
            cyc++;
            busy_n += int'(Busy);
        end
        chk({tag, " done_seen"}, 32'(Done), 32'd1);
        chk({tag, " latency"}, 32'(cyc), (b == 16'd0) ? 32'd1 : 32'd17);
        chk({tag, " busy_cycles"}, 32'(busy_n), (b == 16'd0) ? 32'd0 : 32'd16);
        chk({tag, " quociente"}, 32'(Quociente), 32'(ref_q(a, b)));
        chk({tag, " resto"}, 32'(Resto), 32'(ref_r(a, b)));
        chk({tag, " divzero"}, 32'(DivZero), 32'(b == 16'd0));
        @(negedge Clk);
        chk({tag, " done_pulse"}, 32'(Done), 32'd0);
        chk({tag, " q_held"}, 32'(Quociente), 32'(ref_q(a, b)));
    endtask

    initial begin
        int cyc;
        logic [15:0] a;
        logic [15:0] b;
        vectors = 0;
        miscompares = 0;
        Reset = 1'b1; Start = 1'b0; Dividendo = '0; Divisor = '0;
        repeat (2) @(negedge Clk);
        chk("reset quociente", 32'(Quociente), 32'd0);
        chk("reset resto", 32'(Resto), 32'd0);
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset done", 32'(Done), 32'd0);
        chk("reset divzero", 32'(DivZero), 32'd0);
        Reset = 1'b0;

        do_div(16'd100, 16'd7, "100/7");
        do_div(16'hFFFF, 16'd1, "ffff/1");
        do_div(16'hFFFF, 16'hFFFF, "ffff/ffff");
        do_div(16'd5, 16'd9, "5/9");
        do_div(16'd1234, 16'd0, "1234/0");
        do_div(16'd0, 16'd3, "0/3");

        // Start pulsed mid-operation must be ignored
        @(negedge Clk);
        Start = 1'b1; Dividendo = 16'd100; Divisor = 16'd7;
        @(negedge Clk);
        Start = 1'b0;
        cyc = 1;
        repeat (3) begin @(negedge Clk); cyc++; end
        chk("ignore busy", 32'(Busy), 32'd1);
        Start = 1'b1; Dividendo = 16'd50; Divisor = 16'd3;
        @(negedge Clk);
        cyc++;
        Start = 1'b0;
        while (!Done && cyc < 40) begin @(negedge Clk); cyc++; end
        chk("ignore latency", 32'(cyc), 32'd17);
        chk("ignore quociente", 32'(Quociente), 32'd14);
        chk("ignore resto", 32'(Resto), 32'd2);

        // Start held high: re-accepted right after FIN
        @(negedge Clk);
        Start = 1'b1; Dividendo = 16'd100; Divisor = 16'd7;
        @(negedge Clk);
        cyc = 1;
        while (!Done && cyc < 40) begin @(negedge Clk); cyc++; end
        chk("b2b first latency", 32'(cyc), 32'd17);
        chk("b2b first quociente", 32'(Quociente), 32'd14);
        Dividendo = 16'd9; Divisor = 16'd2;
        @(negedge Clk);
        chk("b2b gap busy", 32'(Busy), 32'd0);
        chk("b2b gap done", 32'(Done), 32'd0);
        chk("b2b gap held", 32'(Resto), 32'd2);
        @(negedge Clk);
        chk("b2b second busy", 32'(Busy), 32'd1);
        Start = 1'b0;
        cyc = 1;
        while (!Done && cyc < 40) begin @(negedge Clk); cyc++; end
        chk("b2b second latency", 32'(cyc), 32'd17);
        chk("b2b second quociente", 32'(Quociente), 32'd4);
        chk("b2b second resto", 32'(Resto), 32'd1);

        // reset in the middle of CALC aborts without Done
        @(negedge Clk);
        Start = 1'b1; Dividendo = 16'd100; Divisor = 16'd7;
        @(negedge Clk);
        Start = 1'b0;
        repeat (7) @(negedge Clk);
        chk("abort busy before", 32'(Busy), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort quociente", 32'(Quociente), 32'd0);
        chk("abort resto", 32'(Resto), 32'd0);
        chk("abort busy", 32'(Busy), 32'd0);
        chk("abort done", 32'(Done), 32'd0);
        cyc = 0;
        repeat (20) begin @(negedge Clk); cyc += int'(Done); end
        chk("abort no done", 32'(cyc), 32'd0);
        do_div(16'd9, 16'd3, "9/3");

        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = (i % 6 == 0) ? 16'd0 : (i % 3 == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom);
            do_div(a, b, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/divisor_restaurador.md
# divisor_restaurador

Sequential unsigned restoring divider, the inverse counterpart of the shift-add multiplier datapath in the Multiplicador area. Given a WIDTH-bit dividend and divisor, it produces quotient and remainder with one shift-subtract step per clock. It holds its own control FSM and a combined remainder/quotient shift register. It sits beside the multiplier as the DIV/DIVU execution unit of the CPU.

## Interface
- WIDTH, 16, operand width in bits (≥ 2)
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request; sampled only in IDLE
- Dividendo  in  WIDTH  dividend, captured on accepted Start
- Divisor  in  WIDTH  divisor, captured on accepted Start
- Quociente  out  WIDTH  quotient, registered
- Resto  out  WIDTH  remainder, registered
- Busy  out  1  high in CALC
- Done  out  1  one-cycle pulse in FIN
- DivZero  out  1  registered; high when the last accepted request had Divisor == 0

## Operation
- Internal state: R (WIDTH+1 bits, remainder), Q (WIDTH bits, quotient/dividend), D (WIDTH bits, latched divisor), Cnt (counts WIDTH down to 0).
- FSM states: IDLE, CALC, FIN.
- IDLE: Busy=0, Done=0. On Start=1:
  - Divisor ≠ 0: R←0, Q←Dividendo, D←Divisor, Cnt←WIDTH, DivZero←0, go to CALC.
  - Divisor = 0: Q←all ones, R←Dividendo, DivZero←1, go to FIN without iterating.
- CALC, one iteration per cycle:
  - Form S = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Compute T = S − {1'b0, D} (WIDTH+1 bits).
  - If T is non-negative (MSB 0): R←T, Q←{Q[WIDTH-2:0], 1}.
  - Otherwise: R←S, Q←{Q[WIDTH-2:0], 0}.
  - Cnt←Cnt−1. Go to FIN on the cycle Cnt becomes 0.
- FIN: Done=1 for exactly one cycle, then unconditionally go to IDLE.
- Outputs: Quociente = Q, Resto = R[WIDTH-1:0]. Both are held stable from FIN until the next accepted Start.
- Arithmetic: all unsigned. R never exceeds D−1 after a commit, so R[WIDTH] is 0 at FIN.
- Start while in CALC or FIN is ignored. It is not queued.
- Start held high is re-accepted on the cycle following FIN (back-to-back operation).

## Timing
- Reset (synchronous, priority over everything): state→IDLE; R, Q, D, Cnt, DivZero → 0; Busy=0, Done=0; Quociente=0, Resto=0.
- Reset asserted mid-CALC aborts the operation and gives no Done pulse.
- Normal case, Start accepted at edge k:
  - Busy is high for edges k+1 through k+WIDTH.
  - Done is high after edge k+WIDTH+1 (WIDTH+1 cycles of latency).
  - Results are valid from the Done cycle.
- Divide by zero: Done is high after edge k+1 (1 cycle of latency), and Busy never rises.
- Operand inputs may change freely after the accepting edge.
- Busy and Done are decoded from the state register only (Moore outputs).

## Structure
- Shared package `div_pkg`:
  - state encoding constants for IDLE, CALC, FIN (2 bits);
  - localparam for the counter width, $clog2(WIDTH+1).
- Sub-module `acc_div`: the R/Q shift-subtract register.
  - Inputs: Load, Step, Clk, Reset, the operands, and D.
  - It computes T internally and mirrors the multiplier's accumulator on the division side.
  - The top level holds the FSM and Cnt.

## Test plan
- WIDTH=16, Dividendo=100, Divisor=7 -> Quociente=14, Resto=2, DivZero=0, Done exactly 17 cycles after the Start edge, Busy high for 16 cycles.
- Dividendo=0xFFFF, Divisor=1 -> Quociente=0xFFFF, Resto=0. Dividendo=0xFFFF, Divisor=0xFFFF -> Quociente=1, Resto=0.
- Dividendo=5, Divisor=9 -> Quociente=0, Resto=5.
- Dividendo=1234, Divisor=0 -> Done after 1 cycle, DivZero=1, Quociente=0xFFFF, Resto=1234, Busy never high.
- Start pulsed with 50/3 while Busy during a 100/7 operation -> ignored; result is 14 r 2. Start held high -> a second operation begins the cycle after FIN.
- Reset asserted at CALC cycle 8 -> next edge: all outputs 0, IDLE, no Done. A new Start with 9/3 -> Quociente=3, Resto=0.
